mem_lsu_stage: RTL

Parametrised successor to the pass-through MEM stage. It sits between the EX/MEM and MEM/WB pipeline registers. Non-memory instructions pass through with registered outputs. Loads and stores run a multi-beat request/ready transaction to the memory controller, assemble or split data across beats, and sign- or zero-extend loads. The pipeline stalls while a transfer is in flight, and misaligned accesses are flagged instead of executed.

---
 rtl/mem_lsu_pkg.sv | 52 +++++
 rtl/mem_lsu_stage_load_ext.sv | 29 ++
 rtl/mem_lsu_stage.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared encodings and helpers for the MEM load/store stage.
// mem_op codes, funct3 width codes, FSM states, reset/zero constants.
package mem_lsu_pkg;

  typedef enum logic [1:0] {
    MOP_NONE  = 2'b00,
    MOP_LOAD  = 2'b01,
    MOP_STORE = 2'b10,
    MOP_RSVD  = 2'b11
  } mem_op_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } lsu_state_e;

  localparam logic        RST_ENABLE   = 1'b0;
  localparam logic [31:0] ZERO_WORD    = 32'h0;
  localparam logic [4:0]  NOP_REG_ADDR = 5'h0;

  function automatic logic [2:0] size_bytes(
    input logic [1:0] sz
  );
    logic [2:0] n;
    unique case (sz)
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic misaligned(
    input logic [1:0] sz,
    input logic [1:0] a
  );
    logic m;
    unique case (sz)
      2'b00:   m = 1'b0;
      2'b01:   m = a[0];
      default: m = (a != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_lsu_stage_load_ext.sv
// Load result extraction: low byte/half/word with sign or zero extension.
// raw_i: assembled load data, funct3_i: width code, ext_o: extended value.
module lsu_load_ext
  import mem_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] raw_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] ext_o
);

  always_comb begin
    ext_o = raw_i;
    unique case (1'b1)
      (funct3_i == F3_B):
        ext_o = {{(XLEN-8){raw_i[7]}}, raw_i[7:0]};
      (funct3_i == F3_H):
        ext_o = {{(XLEN-16){raw_i[15]}}, raw_i[15:0]};
      (funct3_i == F3_BU):
        ext_o = {{(XLEN-8){1'b0}}, raw_i[7:0]};
      (funct3_i == F3_HU):
        ext_o = {{(XLEN-16){1'b0}}, raw_i[15:0]};
      default:
        ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_lsu_stage.sv
// MEM stage: pass-through for ALU ops, multi-beat load/store otherwise.
// EX/MEM inputs, beat bus to memory controller, MEM/WB outputs, stall.
module mem_lsu_stage
  import mem_lsu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ADDR_W     = 32,
  parameter int BEAT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic [XLEN-1:0]       wdata_i,
  input  logic                  wreg_i,
  input  logic [1:0]            mem_op_i,
  input  logic [2:0]            funct3_i,
  input  logic [ADDR_W-1:0]     addr_i,
  output logic                  stall_req_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [BEAT_W-1:0]     mem_wdata_o,
  input  logic [BEAT_W-1:0]     mem_rdata_i,
  input  logic                  mem_ready_i,
  output logic                  out_valid_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic [XLEN-1:0]       wdata_o,
  output logic                  wreg_o,
  output logic                  misalign_o
);

  localparam int BEAT_B = BEAT_W / 8;
  localparam int NB_MAX = XLEN / BEAT_W;
  localparam int CNT_W  = $clog2(NB_MAX + 1);

  function automatic logic [CNT_W-1:0] beats_for(
    input logic [2:0] nb
  );
    int bits;
    bits = int'(nb) * 8;
    return (bits <= BEAT_W) ? CNT_W'(1) : CNT_W'(bits / BEAT_W);
  endfunction

  lsu_state_e state_q, state_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  wreg_q, wreg_d;
  logic                  store_q, store_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [XLEN-1:0]       data_q, data_d;
  logic [2:0]            f3_q, f3_d;
  logic [2:0]            nbytes_q, nbytes_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      nbeats_q, nbeats_d;
  logic [XLEN-1:0]       asm_q, asm_d;
  logic                  ov_q, ov_d;
  logic [REG_ADDR_W-1:0] ord_q, ord_d;
  logic [XLEN-1:0]       owd_q, owd_d;
  logic                  owr_q, owr_d;
  logic                  mis_q, mis_d;

  logic            is_mem, mis_in, last, xfer;
  logic [2:0]      nb_in;
  logic [XLEN-1:0] ext;
  logic [BEAT_W-1:0] beat_wd;

  assign xfer   = (state_q == S_XFER);
  assign is_mem = (mem_op_i == MOP_LOAD)
                | (mem_op_i == MOP_STORE);
  assign nb_in  = size_bytes(funct3_i[1:0]);
  assign mis_in = misaligned(funct3_i[1:0], addr_i[1:0]);
  assign last   = (cnt_q == nbeats_q - CNT_W'(1));

  // Assembly register kept in its own block so the extender can
  // see the final beat in the same cycle it arrives.
  always_comb begin
    asm_d = asm_q;
    if (state_q == S_IDLE && in_valid_i) begin
      asm_d = '0;
    end else if (xfer && mem_ready_i && !store_q) begin
      asm_d[int'(cnt_q)*BEAT_W +: BEAT_W] = mem_rdata_i;
    end
  end

  lsu_load_ext #(.XLEN(XLEN)) u_ext (
    .raw_i    (asm_d),
    .funct3_i (f3_q),
    .ext_o    (ext)
  );

  // Bytes beyond the access size are zeroed inside a wide beat.
  always_comb begin
    beat_wd = data_q[int'(cnt_q)*BEAT_W +: BEAT_W];
    for (int j = 0; j < BEAT_B; j++) begin
      if (j >= int'(nbytes_q)) beat_wd[j*8 +: 8] = 8'h00;
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    wreg_d   = wreg_q;
    store_d  = store_q;
    addr_d   = addr_q;
    data_d   = data_q;
    f3_d     = f3_q;
    nbytes_d = nbytes_q;
    cnt_d    = cnt_q;
    nbeats_d = nbeats_q;
    ov_d     = 1'b0;
    ord_d    = ord_q;
    owd_d    = owd_q;
    owr_d    = owr_q;
    mis_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          if (!is_mem) begin
            ov_d  = 1'b1;
            ord_d = rd_i;
            owd_d = wdata_i;
            owr_d = wreg_i;
          end else if (mis_in) begin
            ov_d  = 1'b1;
            mis_d = 1'b1;
            ord_d = rd_i;
            owd_d = '0;
            owr_d = 1'b0;
          end else begin
            state_d  = S_XFER;
            rd_d     = rd_i;
            wreg_d   = wreg_i;
            store_d  = (mem_op_i == MOP_STORE);
            addr_d   = addr_i;
            data_d   = wdata_i;
            f3_d     = funct3_i;
            nbytes_d = nb_in;
            cnt_d    = '0;
            nbeats_d = beats_for(nb_in);
          end
        end
      end
      S_XFER: begin
        if (mem_ready_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last) begin
            state_d = S_IDLE;
            ov_d    = 1'b1;
            ord_d   = rd_q;
            owd_d   = store_q ? '0 : ext;
            owr_d   = !store_q && wreg_q && (rd_q != '0);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q  <= S_IDLE;
      rd_q     <= '0;
      wreg_q   <= 1'b0;
      store_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      f3_q     <= '0;
      nbytes_q <= '0;
      cnt_q    <= '0;
      nbeats_q <= '0;
      asm_q    <= '0;
      ov_q     <= 1'b0;
      ord_q    <= '0;
      owd_q    <= '0;
      owr_q    <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      wreg_q   <= wreg_d;
      store_q  <= store_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      f3_q     <= f3_d;
      nbytes_q <= nbytes_d;
      cnt_q    <= cnt_d;
      nbeats_q <= nbeats_d;
      asm_q    <= asm_d;
      ov_q     <= ov_d;
      ord_q    <= ord_d;
      owd_q    <= owd_d;
      owr_q    <= owr_d;
      mis_q    <= mis_d;
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign stall_req_o = xfer ? !(mem_ready_i && last)
                            : (in_valid_i && is_mem && !mis_in);
  assign mem_req_o   = xfer;
  assign mem_we_o    = xfer && store_q;
  assign mem_addr_o  = xfer ? addr_q + ADDR_W'(cnt_q) * ADDR_W'(BEAT_B)
                            : '0;
  assign mem_wdata_o = (xfer && store_q) ? beat_wd : '0;
  assign out_valid_o = ov_q;
  assign rd_o        = ord_q;
  assign wdata_o     = owd_q;
  assign wreg_o      = owr_q;
  assign misalign_o  = mis_q;

endmodule
